// File: rtl/core_cache_arb_if.sv
// Requester and cache handshake bundle for core_cache_arb.
// slave is the arbiter's view; master is the requester/cache side.
interface core_cache_arb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  if_req_i;
   logic [ADDR_WIDTH-1:0] if_addr_i;
   logic                  if_addr_ack_o;
   logic                  if_data_ack_o;
   logic [DATA_WIDTH-1:0] if_rd_data_o;

   logic                  ls_req_i;
   logic                  ls_op_i;
   logic [ADDR_WIDTH-1:0] ls_addr_i;
   logic [3:0]            ls_wr_en_i;
   logic [DATA_WIDTH-1:0] ls_wr_data_i;
   logic                  ls_addr_ack_o;
   logic                  ls_data_ack_o;
   logic [DATA_WIDTH-1:0] ls_rd_data_o;

   logic                  cache_req_o;
   logic                  cache_op_o;
   logic [ADDR_WIDTH-1:0] cache_addr_o;
   logic [3:0]            cache_wr_en_o;
   logic [DATA_WIDTH-1:0] cache_wr_data_o;
   logic [DATA_WIDTH-1:0] cache_rd_data_i;
   logic                  cache_addr_ack_i;
   logic                  cache_data_ack_i;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_addr_ack_o, if_data_ack_o, if_rd_data_o,
      input  ls_req_i, ls_op_i, ls_addr_i, ls_wr_en_i, ls_wr_data_i,
      output ls_addr_ack_o, ls_data_ack_o, ls_rd_data_o,
      output cache_req_o, cache_op_o, cache_addr_o, cache_wr_en_o, cache_wr_data_o,
      input  cache_rd_data_i, cache_addr_ack_i, cache_data_ack_i
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_addr_ack_o, if_data_ack_o, if_rd_data_o,
      output ls_req_i, ls_op_i, ls_addr_i, ls_wr_en_i, ls_wr_data_i,
      input  ls_addr_ack_o, ls_data_ack_o, ls_rd_data_o,
      input  cache_req_o, cache_op_o, cache_addr_o, cache_wr_en_o, cache_wr_data_o,
      output cache_rd_data_i, cache_addr_ack_i, cache_data_ack_i
   );
endinterface

// File: rtl/core_cache_arb.sv
// Fetch/LSU arbiter in front of the cache request port: LSU priority with a
// starvation limit for fetch, one outstanding transaction, back-to-back grants.
module core_cache_arb #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   core_cache_arb_if.slave bus,
   output logic busy_o
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t                state;
   logic                  owner;        // 0 = fetch, 1 = LSU
   logic [3:0]            starve_cnt;
   logic                  cache_req;
   logic                  cache_op;
   logic [ADDR_WIDTH-1:0] cache_addr;
   logic [3:0]            cache_wr_en;
   logic [DATA_WIDTH-1:0] cache_wr_data;
   logic [DATA_WIDTH-1:0] if_rd_q;
   logic [DATA_WIDTH-1:0] ls_rd_q;

   logic complete;
   logic grant_ok;
   logic fetch_first;
   logic grant_if;
   logic grant_ls;

   assign complete    = (state == ADDR && bus.cache_addr_ack_i && bus.cache_data_ack_i) ||
                        (state == DATA && bus.cache_data_ack_i);
   // Gating with rst keeps the combinational acks quiet while reset is held.
   assign grant_ok    = !rst && (state == IDLE || complete);
   assign fetch_first = bus.if_req_i && (!bus.ls_req_i || starve_cnt == LIMIT);
   assign grant_if    = grant_ok && fetch_first;
   assign grant_ls    = grant_ok && bus.ls_req_i && !fetch_first;

   assign bus.if_addr_ack_o   = grant_if;
   assign bus.ls_addr_ack_o   = grant_ls;
   assign bus.if_data_ack_o   = complete && !owner;
   assign bus.ls_data_ack_o   = complete && owner;
   assign bus.if_rd_data_o    = (complete && !owner) ? bus.cache_rd_data_i : if_rd_q;
   assign bus.ls_rd_data_o    = (complete && owner)  ? bus.cache_rd_data_i : ls_rd_q;

   assign bus.cache_req_o     = cache_req;
   assign bus.cache_op_o      = cache_op;
   assign bus.cache_addr_o    = cache_addr;
   assign bus.cache_wr_en_o   = cache_wr_en;
   assign bus.cache_wr_data_o = cache_wr_data;
   assign busy_o              = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         owner         <= 1'b0;
         starve_cnt    <= '0;
         cache_req     <= 1'b0;
         cache_op      <= 1'b0;
         cache_addr    <= '0;
         cache_wr_en   <= '0;
         cache_wr_data <= '0;
         if_rd_q       <= '0;
         ls_rd_q       <= '0;
      end else begin
         case (state)
            IDLE: ;
            ADDR: begin
               if (bus.cache_addr_ack_i) begin
                  cache_req <= 1'b0;
                  state     <= bus.cache_data_ack_i ? IDLE : DATA;
               end
            end
            DATA: begin
               if (bus.cache_data_ack_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (complete) begin
            if (owner) ls_rd_q <= bus.cache_rd_data_i;
            else       if_rd_q <= bus.cache_rd_data_i;
         end

         // A grant (from IDLE or the completion cycle) overrides the above.
         if (grant_if) begin
            state         <= ADDR;
            owner         <= 1'b0;
            cache_req     <= 1'b1;
            cache_op      <= 1'b0;
            cache_addr    <= bus.if_addr_i;
            cache_wr_en   <= '0;
            cache_wr_data <= '0;
            starve_cnt    <= '0;
         end else if (grant_ls) begin
            state         <= ADDR;
            owner         <= 1'b1;
            cache_req     <= 1'b1;
            cache_op      <= bus.ls_op_i;
            cache_addr    <= bus.ls_addr_i;
            cache_wr_en   <= bus.ls_op_i ? bus.ls_wr_en_i : 4'b0000;
            cache_wr_data <= bus.ls_wr_data_i;
            if (!bus.if_req_i)          starve_cnt <= '0;
            else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_core_cache_arb.sv
// Directed bench for core_cache_arb: fetch, LSU write, starvation order,
// back-to-back grant, same-cycle acks and reset abort.
module tb_core_cache_arb;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic mon_on = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   core_cache_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   core_cache_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .busy_o (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.if_req_i         = 1'b0;
      bus.if_addr_i        = '0;
      bus.ls_req_i         = 1'b0;
      bus.ls_op_i          = 1'b0;
      bus.ls_addr_i        = '0;
      bus.ls_wr_en_i       = '0;
      bus.ls_wr_data_i     = '0;
      bus.cache_rd_data_i  = '0;
      bus.cache_addr_ack_i = 1'b0;
      bus.cache_data_ack_i = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         check("addr_ack_overlap", {bus.if_addr_ack_o, bus.ls_addr_ack_o} == 2'b11, 0);
         check("data_ack_overlap", {bus.if_data_ack_o, bus.ls_data_ack_o} == 2'b11, 0);
      end
   end

   initial begin
      logic [1:0] exp_grant;

      rst = 1'b1;
      idle_inputs();
      bus.if_req_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sample();
      check("rst_cache_req", bus.cache_req_o, 0);
      check("rst_busy", busy, 0);
      check("rst_if_addr_ack", bus.if_addr_ack_o, 0);
      check("rst_if_rd_data", bus.if_rd_data_o, 0);
      check("rst_cache_addr", bus.cache_addr_o, 0);
      next_cycle();
      bus.if_req_i = 1'b0;
      rst = 1'b0;
      mon_on = 1'b1;

      // Single fetch
      next_cycle();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0000_1000;
      sample();
      check("f_if_addr_ack", bus.if_addr_ack_o, 1);
      check("f_ls_addr_ack", bus.ls_addr_ack_o, 0);
      check("f_req_c0", bus.cache_req_o, 0);
      next_cycle();
      bus.if_req_i = 1'b0; bus.if_addr_i = '0;
      sample();
      check("f_req_c1", bus.cache_req_o, 1);
      check("f_addr_c1", bus.cache_addr_o, 32'h1000);
      check("f_op_c1", bus.cache_op_o, 0);
      check("f_if_addr_ack_c1", bus.if_addr_ack_o, 0);
      next_cycle();
      sample();
      check("f_req_c2", bus.cache_req_o, 1);
      next_cycle();
      bus.cache_addr_ack_i = 1'b1;
      sample();
      check("f_req_c3", bus.cache_req_o, 1);
      check("f_addr_c3", bus.cache_addr_o, 32'h1000);
      next_cycle();
      bus.cache_addr_ack_i = 1'b0;
      sample();
      check("f_req_c4", bus.cache_req_o, 0);
      check("f_busy_c4", busy, 1);
      check("f_data_ack_c4", bus.if_data_ack_o, 0);
      next_cycle();
      bus.cache_data_ack_i = 1'b1; bus.cache_rd_data_i = 32'hDEAD_BEEF;
      sample();
      check("f_data_ack_c5", bus.if_data_ack_o, 1);
      check("f_rd_data_c5", bus.if_rd_data_o, 32'hDEAD_BEEF);
      check("f_ls_data_ack_c5", bus.ls_data_ack_o, 0);
      next_cycle();
      bus.cache_data_ack_i = 1'b0; bus.cache_rd_data_i = '0;
      sample();
      check("f_busy_c6", busy, 0);
      check("f_rd_hold_c6", bus.if_rd_data_o, 32'hDEAD_BEEF);
      check("f_data_ack_c6", bus.if_data_ack_o, 0);

      // LSU write
      next_cycle();
      bus.ls_req_i = 1'b1; bus.ls_op_i = 1'b1; bus.ls_addr_i = 32'h2004;
      bus.ls_wr_en_i = 4'b0011; bus.ls_wr_data_i = 32'h1234_5678;
      sample();
      check("w_ls_addr_ack", bus.ls_addr_ack_o, 1);
      check("w_if_addr_ack", bus.if_addr_ack_o, 0);
      next_cycle();
      bus.ls_req_i = 1'b0; bus.ls_op_i = 1'b0; bus.ls_addr_i = '0;
      bus.ls_wr_en_i = 4'hF; bus.ls_wr_data_i = 32'hFFFF_FFFF;
      sample();
      check("w_op", bus.cache_op_o, 1);
      check("w_wr_en", bus.cache_wr_en_o, 4'b0011);
      check("w_wr_data", bus.cache_wr_data_o, 32'h1234_5678);
      check("w_addr", bus.cache_addr_o, 32'h2004);
      next_cycle();
      bus.cache_addr_ack_i = 1'b1;
      sample();
      check("w_req_held", bus.cache_req_o, 1);
      check("w_wr_data_held", bus.cache_wr_data_o, 32'h1234_5678);
      next_cycle();
      bus.cache_addr_ack_i = 1'b0; bus.cache_data_ack_i = 1'b1; bus.cache_rd_data_i = 32'hAAAA_5555;
      sample();
      check("w_ls_data_ack", bus.ls_data_ack_o, 1);
      check("w_if_data_ack", bus.if_data_ack_o, 0);
      check("w_if_rd_hold", bus.if_rd_data_o, 32'hDEAD_BEEF);
      next_cycle();
      bus.cache_data_ack_i = 1'b0; bus.cache_rd_data_i = '0;
      sample();
      check("w_busy_done", busy, 0);
      check("w_ls_rd_hold", bus.ls_rd_data_o, 32'hAAAA_5555);

      // Contention: both requesting, cache acks immediately
      next_cycle();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
      bus.ls_req_i = 1'b1; bus.ls_op_i = 1'b1; bus.ls_addr_i = 32'h200;
      bus.ls_wr_en_i = 4'hF; bus.ls_wr_data_i = 32'h5A5A_5A5A;
      bus.cache_addr_ack_i = 1'b1; bus.cache_data_ack_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sample();
         exp_grant = (i % 5 == 4) ? 2'b10 : 2'b01;
         check($sformatf("grant_%0d", i), {bus.if_addr_ack_o, bus.ls_addr_ack_o}, exp_grant);
         if (i == 4) check("starve_at_limit", dut.starve_cnt, 4);
         if (i == 5) begin
            check("starve_cleared", dut.starve_cnt, 0);
            check("fetch_op_forced", bus.cache_op_o, 0);
            check("fetch_wr_en_forced", bus.cache_wr_en_o, 0);
            check("fetch_addr", bus.cache_addr_o, 32'h100);
         end
         next_cycle();
      end
      bus.if_req_i = 1'b0; bus.ls_req_i = 1'b0;
      sample();
      check("cont_last_fetch_done", bus.if_data_ack_o, 1);
      next_cycle();
      idle_inputs();
      sample();
      check("cont_busy_done", busy, 0);

      // Back-to-back: LSU pending when fetch data arrives
      next_cycle();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h3000;
      sample();
      check("b2b_if_addr_ack", bus.if_addr_ack_o, 1);
      next_cycle();
      bus.if_req_i = 1'b0; bus.cache_addr_ack_i = 1'b1;
      next_cycle();
      bus.cache_addr_ack_i = 1'b0;
      bus.ls_req_i = 1'b1; bus.ls_op_i = 1'b0; bus.ls_addr_i = 32'h4000;
      sample();
      check("b2b_no_grant_in_data", bus.ls_addr_ack_o, 0);
      next_cycle();
      bus.cache_data_ack_i = 1'b1; bus.cache_rd_data_i = 32'h0000_0055;
      sample();
      check("b2b_if_data_ack", bus.if_data_ack_o, 1);
      check("b2b_ls_addr_ack", bus.ls_addr_ack_o, 1);
      check("b2b_if_rd_data", bus.if_rd_data_o, 32'h55);
      next_cycle();
      bus.ls_req_i = 1'b0; bus.ls_addr_i = '0;
      // Same-cycle addr + data ack in the first ADDR cycle
      bus.cache_addr_ack_i = 1'b1; bus.cache_data_ack_i = 1'b1; bus.cache_rd_data_i = 32'h0BAD_F00D;
      sample();
      check("b2b_req_reassert", bus.cache_req_o, 1);
      check("b2b_ls_addr", bus.cache_addr_o, 32'h4000);
      check("b2b_ls_op", bus.cache_op_o, 0);
      check("same_ls_data_ack", bus.ls_data_ack_o, 1);
      check("same_ls_rd_data", bus.ls_rd_data_o, 32'h0BAD_F00D);
      next_cycle();
      idle_inputs();
      sample();
      check("same_no_data_state", busy, 0);

      // Reset while in DATA
      next_cycle();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h5000;
      next_cycle();
      bus.if_req_i = 1'b0; bus.cache_addr_ack_i = 1'b1;
      next_cycle();
      bus.cache_addr_ack_i = 1'b0;
      sample();
      check("rmid_in_data", busy, 1);
      next_cycle();
      rst = 1'b1; bus.cache_data_ack_i = 1'b1;
      sample();
      check("rmid_cache_req", bus.cache_req_o, 0);
      check("rmid_busy", busy, 0);
      check("rmid_if_data_ack", bus.if_data_ack_o, 0);
      next_cycle();
      rst = 1'b0;
      sample();
      check("stray_if_data_ack", bus.if_data_ack_o, 0);
      check("stray_ls_data_ack", bus.ls_data_ack_o, 0);
      check("stray_busy", busy, 0);
      check("stray_if_rd_data", bus.if_rd_data_o, 0);
      next_cycle();
      idle_inputs();
      sample();
      mon_on = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/core_cache_arb.md
Name: core_cache_arb

Overview:
- Two-requester arbiter/sequencer in front of the core cache request port. Requester 0 is instruction fetch (read-only); requester 1 is the load/store unit (read/write).
- Grants one requester at a time, registers its request, and drives the cache address/data handshake.
- Routes the read data and the acknowledges back to the granted requester.
- LSU has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_WIDTH, 32, byte address width of requester and cache addresses
- DATA_WIDTH, 32, data width
- STARVE_LIMIT, 4, consecutive LSU grants allowed while fetch is pending before fetch is forced; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch read request; held until if_addr_ack_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_addr_ack_o  out  1  fetch request accepted (1-cycle pulse)
- if_data_ack_o  out  1  fetch data valid (1-cycle pulse)
- if_rd_data_o  out  DATA_WIDTH  fetch read data
- ls_req_i  in  1  LSU request; held until ls_addr_ack_o
- ls_op_i  in  1  0 = read, 1 = write
- ls_addr_i  in  ADDR_WIDTH  LSU address
- ls_wr_en_i  in  4  byte write enables
- ls_wr_data_i  in  DATA_WIDTH  write data
- ls_addr_ack_o  out  1  LSU request accepted (pulse)
- ls_data_ack_o  out  1  LSU transfer complete (pulse; reads and writes)
- ls_rd_data_o  out  DATA_WIDTH  LSU read data
- cache_req_o  out  1  request to cache
- cache_op_o  out  1  0 = read, 1 = write
- cache_addr_o  out  ADDR_WIDTH  registered request address
- cache_wr_en_o  out  4  registered byte enables (0 for reads)
- cache_wr_data_o  out  DATA_WIDTH  registered write data
- cache_rd_data_i  in  DATA_WIDTH  cache read data
- cache_addr_ack_i  in  1  cache accepted the address
- cache_data_ack_i  in  1  cache transfer done; rd_data valid this cycle
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; owner 0; starve_cnt 0; all cache_* outputs 0; all ack outputs 0; rd_data outputs 0; busy_o 0. Reset asserted mid-transaction aborts it immediately, with no ack. Any later cache ack is ignored while in IDLE.
- FSM states:
  - IDLE: if a grant is possible, go to ADDR.
  - ADDR: cache_req_o = 1 until cache_addr_ack_i is seen, then go to DATA. A same-cycle cache_data_ack_i is legal: go straight to completion.
  - DATA: wait for cache_data_ack_i, then complete.
- Grant (evaluated in IDLE, or in the completion cycle for back-to-back operation):
  - Only ls_req_i set: grant LSU.
  - Only if_req_i set: grant fetch.
  - Both set: grant fetch if starve_cnt == STARVE_LIMIT, else grant LSU.
- On the grant edge:
  - Latch op/addr/wr_en/wr_data into the cache_* registers (fetch forces op = 0, wr_en = 0).
  - Record owner.
  - Pulse the owner's *_addr_ack_o in the grant cycle (combinational with the grant decision). The requester may drop or change its request the next cycle.
- starve_cnt:
  - Increments on an LSU grant while if_req_i = 1, saturating at STARVE_LIMIT.
  - Clears on any fetch grant, and when if_req_i = 0 at an LSU grant.
- Cache-side signals are stable from the cycle after grant until cache_addr_ack_i. cache_req_o deasserts in the cycle after the addr ack.
- Completion (cache_data_ack_i in ADDR-after-ack or DATA):
  - owner's *_data_ack_o = 1 and *_rd_data_o = cache_rd_data_i, same cycle (combinational).
  - Non-owner data ack = 0; non-owner rd_data holds its last value (registered copy).
  - If a request is pending, grant in this same cycle, load the registers, and go to ADDR. This gives zero idle cycles between transactions. Otherwise go to IDLE.
- Only one transaction is outstanding at a time. A new grant never occurs while in ADDR or in DATA before completion.
- Latency: request to cache_req_o is 1 cycle; cache_data_ack_i to requester data ack is 0 cycles.
- Requester ack pulses never overlap: at most one of if_addr_ack_o / ls_addr_ack_o per cycle, and likewise for the data acks.

Test Plan:
- Single fetch: if_req_i = 1, addr 0x0000_1000; cache addr_ack at cycle 3, data_ack at cycle 5 with 0xDEAD_BEEF. Required: if_addr_ack_o at cycle 0; cache_req_o at cycles 1–3 with addr 0x1000 and op 0; if_data_ack_o and if_rd_data_o = 0xDEAD_BEEF at cycle 5; ls_* acks remain 0.
- LSU write: ls_op_i = 1, addr 0x2004, wr_en 4'b0011, data 0x1234_5678. Required: cache_op_o = 1, cache_wr_en_o = 0011, cache_wr_data_o = 0x1234_5678 held until addr_ack; ls_data_ack_o on data_ack.
- Contention/starvation with STARVE_LIMIT = 4: both requesters assert continuously, cache acks immediately. Required grant order: LSU ×4, then fetch, then LSU ×4, repeating; starve_cnt returns to 0 after each fetch grant.
- Back-to-back: a pending LSU request is present when a fetch's data_ack arrives. Required: ls_addr_ack_o in the same cycle as if_data_ack_o; cache_req_o reasserts the next cycle with the LSU address and no IDLE cycle.
- Same-cycle acks: cache_addr_ack_i and cache_data_ack_i both asserted in the first ADDR cycle. Required: completion in that cycle; the FSM never enters DATA.
- Reset mid-operation: assert rst while in DATA. Required: cache_req_o = 0, busy_o = 0, no data ack. A stray cache_data_ack_i after reset release produces no requester ack.
